// File: rtl/spl_mux_adaptor_if.sv
// Bus bundle between the multi-channel AFU side and the SPL TX/RX pins.
interface spl_mux_adaptor_if #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TXHDR_WIDTH = 99,
  parameter int unsigned RXHDR_WIDTH = 24,
  parameter int unsigned CACHE_WIDTH = 512
);
  logic                          spl_enable;
  logic [NUM_CH-1:0]             ch_rd_valid;
  logic [NUM_CH*TXHDR_WIDTH-1:0] ch_rd_hdr;
  logic [NUM_CH-1:0]             ch_rd_almostfull;
  logic [NUM_CH-1:0]             ch_wr_valid;
  logic [NUM_CH*TXHDR_WIDTH-1:0] ch_wr_hdr;
  logic [NUM_CH*CACHE_WIDTH-1:0] ch_wr_data;
  logic [NUM_CH-1:0]             ch_wr_almostfull;
  logic                          spl_tx_rd_almostfull;
  logic                          afu_tx_rd_valid;
  logic [TXHDR_WIDTH-1:0]        afu_tx_rd_hdr;
  logic                          spl_tx_wr_almostfull;
  logic                          afu_tx_wr_valid;
  logic [TXHDR_WIDTH-1:0]        afu_tx_wr_hdr;
  logic [CACHE_WIDTH-1:0]        afu_tx_data;
  logic                          spl_rx_rd_valid;
  logic                          spl_rx_wr_valid0;
  logic [RXHDR_WIDTH-1:0]        spl_rx_hdr0;
  logic [CACHE_WIDTH-1:0]        spl_rx_data;
  logic                          spl_rx_wr_valid1;
  logic [RXHDR_WIDTH-1:0]        spl_rx_hdr1;
  logic [NUM_CH-1:0]             ch_rx_rd_valid;
  logic [NUM_CH-1:0]             ch_rx_wr_valid0;
  logic [NUM_CH-1:0]             ch_rx_wr_valid1;
  logic [RXHDR_WIDTH-1:0]        ch_rx_hdr0;
  logic [RXHDR_WIDTH-1:0]        ch_rx_hdr1;
  logic [CACHE_WIDTH-1:0]        ch_rx_data;
  logic [NUM_CH-1:0]             err_overflow;
  logic                          err_badtag;

  // Adaptor view.
  modport slave (
    input  spl_enable, ch_rd_valid, ch_rd_hdr, ch_wr_valid, ch_wr_hdr, ch_wr_data,
           spl_tx_rd_almostfull, spl_tx_wr_almostfull,
           spl_rx_rd_valid, spl_rx_wr_valid0, spl_rx_hdr0, spl_rx_data,
           spl_rx_wr_valid1, spl_rx_hdr1,
    output ch_rd_almostfull, ch_wr_almostfull,
           afu_tx_rd_valid, afu_tx_rd_hdr, afu_tx_wr_valid, afu_tx_wr_hdr, afu_tx_data,
           ch_rx_rd_valid, ch_rx_wr_valid0, ch_rx_wr_valid1,
           ch_rx_hdr0, ch_rx_hdr1, ch_rx_data, err_overflow, err_badtag
  );

  // Environment view (AFU engines plus SPL pins).
  modport master (
    output spl_enable, ch_rd_valid, ch_rd_hdr, ch_wr_valid, ch_wr_hdr, ch_wr_data,
           spl_tx_rd_almostfull, spl_tx_wr_almostfull,
           spl_rx_rd_valid, spl_rx_wr_valid0, spl_rx_hdr0, spl_rx_data,
           spl_rx_wr_valid1, spl_rx_hdr1,
    input  ch_rd_almostfull, ch_wr_almostfull,
           afu_tx_rd_valid, afu_tx_rd_hdr, afu_tx_wr_valid, afu_tx_wr_hdr, afu_tx_data,
           ch_rx_rd_valid, ch_rx_wr_valid0, ch_rx_wr_valid1,
           ch_rx_hdr0, ch_rx_hdr1, ch_rx_data, err_overflow, err_badtag
  );
endinterface

// File: rtl/spl_mux_adaptor.sv
// Multi-channel SPL adaptor: per-channel request FIFOs, round-robin TX
// arbitration with channel-id tag stamping, and tag-based RX routing.
module spl_mux_adaptor #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TXHDR_WIDTH = 99,
  parameter int unsigned RXHDR_WIDTH = 24,
  parameter int unsigned CACHE_WIDTH = 512,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned AF_THRESH   = 2,
  parameter int unsigned TX_TAG_LSB  = 0,
  parameter int unsigned RX_TAG_LSB  = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  spl_mux_adaptor_if.slave   bus
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;

  // FIFO storage and bookkeeping
  logic [TXHDR_WIDTH-1:0] rd_mem_q  [NUM_CH][FIFO_DEPTH];
  logic [TXHDR_WIDTH-1:0] wr_mem_q  [NUM_CH][FIFO_DEPTH];
  logic [CACHE_WIDTH-1:0] wrd_mem_q [NUM_CH][FIFO_DEPTH];

  logic [CW-1:0] rd_cnt_q [NUM_CH];
  logic [CW-1:0] rd_cnt_d [NUM_CH];
  logic [AW-1:0] rd_wp_q  [NUM_CH];
  logic [AW-1:0] rd_wp_d  [NUM_CH];
  logic [AW-1:0] rd_rp_q  [NUM_CH];
  logic [AW-1:0] rd_rp_d  [NUM_CH];
  logic [CW-1:0] wr_cnt_q [NUM_CH];
  logic [CW-1:0] wr_cnt_d [NUM_CH];
  logic [AW-1:0] wr_wp_q  [NUM_CH];
  logic [AW-1:0] wr_wp_d  [NUM_CH];
  logic [AW-1:0] wr_rp_q  [NUM_CH];
  logic [AW-1:0] wr_rp_d  [NUM_CH];

  logic [NUM_CH-1:0] rd_ne_c, wr_ne_c, rd_push_c, wr_push_c, rd_pop_c, wr_pop_c;
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  // Arbiter state
  logic [CH_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CH_W-1:0] rd_gnt_c, wr_gnt_c;
  logic            rd_req_c, wr_req_c;

  // TX output registers
  logic                   tx_rd_valid_q, tx_rd_valid_d;
  logic [TXHDR_WIDTH-1:0] tx_rd_hdr_q, tx_rd_hdr_d;
  logic                   tx_wr_valid_q, tx_wr_valid_d;
  logic [TXHDR_WIDTH-1:0] tx_wr_hdr_q, tx_wr_hdr_d;
  logic [CACHE_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [TXHDR_WIDTH-1:0] rd_hdr_c, wr_hdr_c;

  // RX output registers
  logic [NUM_CH-1:0]      rx_rd_q, rx_rd_d, rx_wr0_q, rx_wr0_d, rx_wr1_q, rx_wr1_d;
  logic [RXHDR_WIDTH-1:0] rx_hdr0_q, rx_hdr1_q;
  logic [CACHE_WIDTH-1:0] rx_data_q;
  logic                   badtag_q, badtag_d;
  logic [CH_W-1:0]        t0_c, t1_c;

  // First non-empty channel at or after ptr.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] ne,
                                              input logic [CH_W-1:0]   ptr);
    logic [CH_W-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && ne[CH_W'(idx)]) begin
        pick  = CH_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Pointer advance past the granted channel, modulo NUM_CH.
  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] gnt);
    int unsigned nx;
    nx = 32'(gnt) + 1;
    if (nx >= NUM_CH) nx = 0;
    return CH_W'(nx);
  endfunction

  // Round-robin grant per path, gated by enable and SPL backpressure.
  always_comb begin
    rd_ne_c  = '0;
    wr_ne_c  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rd_ne_c[i] = (rd_cnt_q[i] != '0);
      wr_ne_c[i] = (wr_cnt_q[i] != '0);
    end
    rd_req_c = bus.spl_enable & ~bus.spl_tx_rd_almostfull & (|rd_ne_c);
    wr_req_c = bus.spl_enable & ~bus.spl_tx_wr_almostfull & (|wr_ne_c);
    rd_gnt_c = rr_pick(rd_ne_c, rd_ptr_q);
    wr_gnt_c = rr_pick(wr_ne_c, wr_ptr_q);
    rd_pop_c = rd_req_c ? (NUM_CH'(1) << rd_gnt_c) : '0;
    wr_pop_c = wr_req_c ? (NUM_CH'(1) << wr_gnt_c) : '0;
    rd_ptr_d = rd_req_c ? rr_next(rd_gnt_c) : rd_ptr_q;
    wr_ptr_d = wr_req_c ? rr_next(wr_gnt_c) : wr_ptr_q;
  end

  // FIFO push/pop accounting; a push into a full FIFO is kept only with a same-cycle pop.
  always_comb begin
    rd_push_c = '0;
    wr_push_c = '0;
    ovf_d     = ovf_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rd_push_c[i] = bus.ch_rd_valid[i] & ((rd_cnt_q[i] != CW'(FIFO_DEPTH)) | rd_pop_c[i]);
      wr_push_c[i] = bus.ch_wr_valid[i] & ((wr_cnt_q[i] != CW'(FIFO_DEPTH)) | wr_pop_c[i]);
      if ((bus.ch_rd_valid[i] & ~rd_push_c[i]) | (bus.ch_wr_valid[i] & ~wr_push_c[i]))
        ovf_d[i] = 1'b1;
      rd_wp_d[i]  = rd_wp_q[i] + AW'(rd_push_c[i]);
      rd_rp_d[i]  = rd_rp_q[i] + AW'(rd_pop_c[i]);
      rd_cnt_d[i] = rd_cnt_q[i] + CW'(rd_push_c[i]) - CW'(rd_pop_c[i]);
      wr_wp_d[i]  = wr_wp_q[i] + AW'(wr_push_c[i]);
      wr_rp_d[i]  = wr_rp_q[i] + AW'(wr_pop_c[i]);
      wr_cnt_d[i] = wr_cnt_q[i] + CW'(wr_push_c[i]) - CW'(wr_pop_c[i]);
    end
  end

  // Head-of-FIFO selection, tag stamping, hold-last on idle cycles.
  always_comb begin
    rd_hdr_c = rd_mem_q[rd_gnt_c][rd_rp_q[rd_gnt_c]];
    rd_hdr_c[TX_TAG_LSB +: CH_W] = rd_gnt_c;
    wr_hdr_c = wr_mem_q[wr_gnt_c][wr_rp_q[wr_gnt_c]];
    wr_hdr_c[TX_TAG_LSB +: CH_W] = wr_gnt_c;
    tx_rd_valid_d = rd_req_c;
    tx_rd_hdr_d   = rd_req_c ? rd_hdr_c : tx_rd_hdr_q;
    tx_wr_valid_d = wr_req_c;
    tx_wr_hdr_d   = wr_req_c ? wr_hdr_c : tx_wr_hdr_q;
    tx_data_d     = wr_req_c ? wrd_mem_q[wr_gnt_c][wr_rp_q[wr_gnt_c]] : tx_data_q;
  end

  // RX one-hot routing by tag; out-of-range tags are dropped and flagged.
  always_comb begin
    t0_c     = bus.spl_rx_hdr0[RX_TAG_LSB +: CH_W];
    t1_c     = bus.spl_rx_hdr1[RX_TAG_LSB +: CH_W];
    rx_rd_d  = '0;
    rx_wr0_d = '0;
    rx_wr1_d = '0;
    badtag_d = badtag_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rx_rd_d[i]  = bus.spl_enable & bus.spl_rx_rd_valid  & (32'(t0_c) == i);
      rx_wr0_d[i] = bus.spl_enable & bus.spl_rx_wr_valid0 & (32'(t0_c) == i);
      rx_wr1_d[i] = bus.spl_enable & bus.spl_rx_wr_valid1 & (32'(t1_c) == i);
    end
    if (bus.spl_enable &
        (((bus.spl_rx_rd_valid | bus.spl_rx_wr_valid0) & (32'(t0_c) >= NUM_CH)) |
         (bus.spl_rx_wr_valid1 & (32'(t1_c) >= NUM_CH))))
      badtag_d = 1'b1;
  end

  // FIFO storage writes (no reset needed; validity tracked by counts).
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_push_c[i])
        rd_mem_q[i][rd_wp_q[i]] <= bus.ch_rd_hdr[i*TXHDR_WIDTH +: TXHDR_WIDTH];
      if (wr_push_c[i]) begin
        wr_mem_q[i][wr_wp_q[i]]  <= bus.ch_wr_hdr[i*TXHDR_WIDTH +: TXHDR_WIDTH];
        wrd_mem_q[i][wr_wp_q[i]] <= bus.ch_wr_data[i*CACHE_WIDTH +: CACHE_WIDTH];
      end
    end
  end

  // Control and output state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        rd_cnt_q[i] <= '0;
        rd_wp_q[i]  <= '0;
        rd_rp_q[i]  <= '0;
        wr_cnt_q[i] <= '0;
        wr_wp_q[i]  <= '0;
        wr_rp_q[i]  <= '0;
      end
      ovf_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tx_rd_valid_q <= 1'b0;
      tx_rd_hdr_q   <= '0;
      tx_wr_valid_q <= 1'b0;
      tx_wr_hdr_q   <= '0;
      tx_data_q     <= '0;
      rx_rd_q       <= '0;
      rx_wr0_q      <= '0;
      rx_wr1_q      <= '0;
      rx_hdr0_q     <= '0;
      rx_hdr1_q     <= '0;
      rx_data_q     <= '0;
      badtag_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        rd_cnt_q[i] <= rd_cnt_d[i];
        rd_wp_q[i]  <= rd_wp_d[i];
        rd_rp_q[i]  <= rd_rp_d[i];
        wr_cnt_q[i] <= wr_cnt_d[i];
        wr_wp_q[i]  <= wr_wp_d[i];
        wr_rp_q[i]  <= wr_rp_d[i];
      end
      ovf_q         <= ovf_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tx_rd_valid_q <= tx_rd_valid_d;
      tx_rd_hdr_q   <= tx_rd_hdr_d;
      tx_wr_valid_q <= tx_wr_valid_d;
      tx_wr_hdr_q   <= tx_wr_hdr_d;
      tx_data_q     <= tx_data_d;
      rx_rd_q       <= rx_rd_d;
      rx_wr0_q      <= rx_wr0_d;
      rx_wr1_q      <= rx_wr1_d;
      rx_hdr0_q     <= bus.spl_rx_hdr0;
      rx_hdr1_q     <= bus.spl_rx_hdr1;
      rx_data_q     <= bus.spl_rx_data;
      badtag_q      <= badtag_d;
    end
  end

  // Almostfull decoded from the registered counts.
  always_comb begin
    bus.ch_rd_almostfull = '0;
    bus.ch_wr_almostfull = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      bus.ch_rd_almostfull[i] = (rd_cnt_q[i] >= CW'(FIFO_DEPTH - AF_THRESH));
      bus.ch_wr_almostfull[i] = (wr_cnt_q[i] >= CW'(FIFO_DEPTH - AF_THRESH));
    end
  end

  assign bus.afu_tx_rd_valid = tx_rd_valid_q;
  assign bus.afu_tx_rd_hdr   = tx_rd_hdr_q;
  assign bus.afu_tx_wr_valid = tx_wr_valid_q;
  assign bus.afu_tx_wr_hdr   = tx_wr_hdr_q;
  assign bus.afu_tx_data     = tx_data_q;
  assign bus.ch_rx_rd_valid  = rx_rd_q;
  assign bus.ch_rx_wr_valid0 = rx_wr0_q;
  assign bus.ch_rx_wr_valid1 = rx_wr1_q;
  assign bus.ch_rx_hdr0      = rx_hdr0_q;
  assign bus.ch_rx_hdr1      = rx_hdr1_q;
  assign bus.ch_rx_data      = rx_data_q;
  assign bus.err_overflow    = ovf_q;
  assign bus.err_badtag      = badtag_q;

endmodule

// File: tb/tb_spl_mux_adaptor.sv
// Directed bench for spl_mux_adaptor: a 4-channel and a 3-channel instance.
module tb_spl_mux_adaptor;

  localparam int unsigned TXW = 99;
  localparam int unsigned RXW = 24;
  localparam int unsigned DW  = 512;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spl_mux_adaptor_if #(.NUM_CH(4)) if4 ();
  spl_mux_adaptor_if #(.NUM_CH(3)) if3 ();

  spl_mux_adaptor #(.NUM_CH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));
  spl_mux_adaptor #(.NUM_CH(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if4.spl_enable = 1'b1;  if3.spl_enable = 1'b1;
    if4.ch_rd_valid = '0;   if3.ch_rd_valid = '0;
    if4.ch_rd_hdr = '0;     if3.ch_rd_hdr = '0;
    if4.ch_wr_valid = '0;   if3.ch_wr_valid = '0;
    if4.ch_wr_hdr = '0;     if3.ch_wr_hdr = '0;
    if4.ch_wr_data = '0;    if3.ch_wr_data = '0;
    if4.spl_tx_rd_almostfull = 1'b0; if3.spl_tx_rd_almostfull = 1'b0;
    if4.spl_tx_wr_almostfull = 1'b0; if3.spl_tx_wr_almostfull = 1'b0;
    if4.spl_rx_rd_valid = 1'b0;  if3.spl_rx_rd_valid = 1'b0;
    if4.spl_rx_wr_valid0 = 1'b0; if3.spl_rx_wr_valid0 = 1'b0;
    if4.spl_rx_wr_valid1 = 1'b0; if3.spl_rx_wr_valid1 = 1'b0;
    if4.spl_rx_hdr0 = '0; if3.spl_rx_hdr0 = '0;
    if4.spl_rx_hdr1 = '0; if3.spl_rx_hdr1 = '0;
    if4.spl_rx_data = '0; if3.spl_rx_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (if4.afu_tx_rd_valid !== 1'b0 || if4.afu_tx_wr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_tx_valid: got rd=%b wr=%b expected 0 0", if4.afu_tx_rd_valid, if4.afu_tx_wr_valid);
    end
    checks++;
    if (if4.afu_tx_rd_hdr !== '0 || if4.afu_tx_wr_hdr !== '0 || if4.afu_tx_data !== '0) begin
      errors++; $display("FAIL reset_tx_payload: nonzero header/data after reset");
    end
    checks++;
    if (if4.ch_rd_almostfull !== 4'b0 || if4.ch_wr_almostfull !== 4'b0) begin
      errors++; $display("FAIL reset_almostfull: got rd=%b wr=%b expected 0000", if4.ch_rd_almostfull, if4.ch_wr_almostfull);
    end
    checks++;
    if (if4.err_overflow !== 4'b0 || if4.err_badtag !== 1'b0 || if4.ch_rx_rd_valid !== 4'b0) begin
      errors++; $display("FAIL reset_err_rx: got ovf=%b bad=%b rxrd=%b expected 0", if4.err_overflow, if4.err_badtag, if4.ch_rx_rd_valid);
    end
  endtask

  // Single ch2 read: visible two cycles after the push, tag stamped into [1:0].
  task automatic test_single_rd();
    do_reset();
    for (int i = 0; i < 8; i++) step();
    if4.ch_rd_hdr[2*TXW +: TXW] = 99'h55;
    if4.ch_rd_valid = 4'b0100;
    step();
    if4.ch_rd_valid = 4'b0000;
    checks++;
    if (if4.afu_tx_rd_valid !== 1'b0) begin
      errors++; $display("FAIL t1_early: valid=%b at N+1 expected 0", if4.afu_tx_rd_valid);
    end
    step();
    checks++;
    if (if4.afu_tx_rd_valid !== 1'b1 || if4.afu_tx_rd_hdr !== 99'h56) begin
      errors++; $display("FAIL t1_emit: valid=%b hdr=%h expected 1 56", if4.afu_tx_rd_valid, if4.afu_tx_rd_hdr);
    end
    step();
    checks++;
    if (if4.afu_tx_rd_valid !== 1'b0 || if4.afu_tx_rd_hdr !== 99'h56) begin
      errors++; $display("FAIL t1_hold: valid=%b hdr=%h expected 0 56", if4.afu_tx_rd_valid, if4.afu_tx_rd_hdr);
    end
  endtask

  // Two reads per channel: strict ch0..ch3 rotation on back-to-back cycles.
  task automatic test_round_robin();
    do_reset();
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 4; i++) if4.ch_rd_hdr[i*TXW +: TXW] = 99'((j*4 + i) << 4);
      if4.ch_rd_valid = 4'hF;
      step();
    end
    if4.ch_rd_valid = 4'h0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (if4.afu_tx_rd_valid !== 1'b1 || if4.afu_tx_rd_hdr !== 99'((k << 4) | (k % 4))) begin
        errors++; $display("FAIL t2_order[%0d]: valid=%b hdr=%h expected 1 %h", k, if4.afu_tx_rd_valid, if4.afu_tx_rd_hdr, 99'((k << 4) | (k % 4)));
      end
      step();
    end
    checks++;
    if (if4.afu_tx_rd_valid !== 1'b0) begin
      errors++; $display("FAIL t2_drained: valid=%b expected 0", if4.afu_tx_rd_valid);
    end
  endtask

  // Backpressured ch1 writes: almostfull at 6, overflow on 9th, 8 emitted on release.
  task automatic test_wr_backpressure();
    logic [DW-1:0] d;
    int emitted;
    do_reset();
    if4.spl_tx_wr_almostfull = 1'b1;
    for (int n = 0; n < 9; n++) begin
      d = {16{32'(32'hC0DE_0000 + n)}};
      if4.ch_wr_hdr[1*TXW +: TXW] = 99'(n << 4);
      if4.ch_wr_data[1*DW +: DW] = d;
      if4.ch_wr_valid = 4'b0010;
      step();
      if (n == 4) begin
        checks++;
        if (if4.ch_wr_almostfull !== 4'b0000) begin
          errors++; $display("FAIL t3_af_count5: got %b expected 0000", if4.ch_wr_almostfull);
        end
      end
      if (n == 5) begin
        checks++;
        if (if4.ch_wr_almostfull !== 4'b0010) begin
          errors++; $display("FAIL t3_af_count6: got %b expected 0010", if4.ch_wr_almostfull);
        end
      end
      if (n == 7) begin
        checks++;
        if (if4.err_overflow !== 4'b0000) begin
          errors++; $display("FAIL t3_no_ovf_at_full: got %b expected 0000", if4.err_overflow);
        end
      end
    end
    if4.ch_wr_valid = 4'b0000;
    checks++;
    if (if4.err_overflow !== 4'b0010 || if4.afu_tx_wr_valid !== 1'b0) begin
      errors++; $display("FAIL t3_ovf: ovf=%b txvalid=%b expected 0010 0", if4.err_overflow, if4.afu_tx_wr_valid);
    end
    if4.spl_tx_wr_almostfull = 1'b0;
    emitted = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (if4.afu_tx_wr_valid === 1'b1) begin
        d = {16{32'(32'hC0DE_0000 + emitted)}};
        checks++;
        if (if4.afu_tx_wr_hdr !== 99'((emitted << 4) | 1) || if4.afu_tx_data !== d) begin
          errors++; $display("FAIL t3_payload[%0d]: hdr=%h expected %h data[31:0]=%h expected %h", emitted, if4.afu_tx_wr_hdr, 99'((emitted << 4) | 1), if4.afu_tx_data[31:0], d[31:0]);
        end
        emitted++;
      end
    end
    checks++;
    if (emitted != 8) begin
      errors++; $display("FAIL t3_emit_count: got %0d expected 8", emitted);
    end
    checks++;
    if (if4.ch_wr_almostfull !== 4'b0000 || if4.err_overflow !== 4'b0010) begin
      errors++; $display("FAIL t3_after_drain: af=%b ovf=%b expected 0000 0010", if4.ch_wr_almostfull, if4.err_overflow);
    end
  endtask

  // RX routing on tag 3 for RX0 and RX1 together, plus enable gating.
  task automatic test_rx_routing();
    logic [DW-1:0] d;
    do_reset();
    d = {64{8'hAB}};
    if4.spl_rx_hdr0 = 24'h000003;
    if4.spl_rx_data = d;
    if4.spl_rx_rd_valid = 1'b1;
    if4.spl_rx_hdr1 = 24'h000107;
    if4.spl_rx_wr_valid1 = 1'b1;
    step();
    if4.spl_rx_rd_valid = 1'b0;
    if4.spl_rx_wr_valid1 = 1'b0;
    checks++;
    if (if4.ch_rx_rd_valid !== 4'b1000 || if4.ch_rx_data !== d) begin
      errors++; $display("FAIL t4_rd: valid=%b data[31:0]=%h expected 1000 abababab", if4.ch_rx_rd_valid, if4.ch_rx_data[31:0]);
    end
    checks++;
    if (if4.ch_rx_wr_valid1 !== 4'b1000 || if4.ch_rx_hdr1 !== 24'h000107 || if4.ch_rx_wr_valid0 !== 4'b0000) begin
      errors++; $display("FAIL t4_wr1: wr1=%b hdr1=%h wr0=%b expected 1000 000107 0000", if4.ch_rx_wr_valid1, if4.ch_rx_hdr1, if4.ch_rx_wr_valid0);
    end
    step();
    checks++;
    if (if4.ch_rx_rd_valid !== 4'b0000 || if4.ch_rx_wr_valid1 !== 4'b0000 || if4.err_badtag !== 1'b0) begin
      errors++; $display("FAIL t4_pulse: rd=%b wr1=%b bad=%b expected 0000 0000 0", if4.ch_rx_rd_valid, if4.ch_rx_wr_valid1, if4.err_badtag);
    end
    if4.spl_enable = 1'b0;
    if4.spl_rx_hdr0 = 24'h000021;
    if4.spl_rx_wr_valid0 = 1'b1;
    step();
    if4.spl_rx_wr_valid0 = 1'b0;
    if4.spl_enable = 1'b1;
    checks++;
    if (if4.ch_rx_wr_valid0 !== 4'b0000 || if4.ch_rx_hdr0 !== 24'h000021) begin
      errors++; $display("FAIL t4_disabled: wr0=%b hdr0=%h expected 0000 000021", if4.ch_rx_wr_valid0, if4.ch_rx_hdr0);
    end
  endtask

  // Three-channel instance: tag 2 routes, tag 3 is dropped and flagged.
  task automatic test_badtag();
    do_reset();
    if3.spl_rx_hdr0 = 24'h000002;
    if3.spl_rx_rd_valid = 1'b1;
    step();
    checks++;
    if (if3.ch_rx_rd_valid !== 3'b100 || if3.err_badtag !== 1'b0) begin
      errors++; $display("FAIL t5_tag2: rd=%b bad=%b expected 100 0", if3.ch_rx_rd_valid, if3.err_badtag);
    end
    if3.spl_rx_hdr0 = 24'h000003;
    step();
    if3.spl_rx_rd_valid = 1'b0;
    checks++;
    if (if3.ch_rx_rd_valid !== 3'b000 || if3.err_badtag !== 1'b1) begin
      errors++; $display("FAIL t5_tag3: rd=%b bad=%b expected 000 1", if3.ch_rx_rd_valid, if3.err_badtag);
    end
    step();
    checks++;
    if (if3.err_badtag !== 1'b1 || if4.err_badtag !== 1'b0) begin
      errors++; $display("FAIL t5_sticky: bad3=%b bad4=%b expected 1 0", if3.err_badtag, if4.err_badtag);
    end
  endtask

  // Reset with queued requests and a pending overflow flushes everything.
  task automatic test_reset_flush();
    int seen;
    do_reset();
    if4.spl_tx_rd_almostfull = 1'b1;
    if4.spl_tx_wr_almostfull = 1'b1;
    for (int n = 0; n < 5; n++) begin
      if4.ch_rd_hdr[0 +: TXW] = 99'(n << 4);
      if4.ch_rd_valid = 4'b0001;
      step();
    end
    if4.ch_rd_valid = 4'b0000;
    for (int n = 0; n < 9; n++) begin
      if4.ch_wr_valid = 4'b0100;
      step();
    end
    if4.ch_wr_valid = 4'b0000;
    checks++;
    if (if4.err_overflow !== 4'b0100 || if4.ch_wr_almostfull !== 4'b0100) begin
      errors++; $display("FAIL t6_prefill: ovf=%b af=%b expected 0100 0100", if4.err_overflow, if4.ch_wr_almostfull);
    end
    reset_n = 1'b0;
    if4.spl_tx_rd_almostfull = 1'b0;
    if4.spl_tx_wr_almostfull = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if (if4.ch_wr_almostfull !== 4'b0000 || if4.ch_rd_almostfull !== 4'b0000 || if4.err_overflow !== 4'b0000) begin
      errors++; $display("FAIL t6_cleared: af_wr=%b af_rd=%b ovf=%b expected 0", if4.ch_wr_almostfull, if4.ch_rd_almostfull, if4.err_overflow);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (if4.afu_tx_rd_valid === 1'b1 || if4.afu_tx_wr_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL t6_no_tx: got %0d tx cycles expected 0", seen);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_rd();
    test_round_robin();
    test_wr_backpressure();
    test_rx_routing();
    test_badtag();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
